bt656_decoder: RTL and testbench



---
 rtl/bt656_pkg.sv | 32 +++
 rtl/bt656_trs_detect.sv | 74 +++++++
 rtl/bt656_decoder.sv | 198 +++++++++++++++++++
 tb/tb_bt656_decoder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bt656_pkg.sv
// Shared constants, state encoding and helpers for the BT.656 front end.
// BT656_PROT_CHECK_EN (optional) enables the XY protection-bit check.
package bt656_pkg;

    localparam logic [7:0] TRS_FF = 8'hFF;
    localparam logic [7:0] TRS_00 = 8'h00;

    localparam int EOP_BIT = 17;
    localparam int SOP_BIT = 16;
    localparam int C_MSB   = 15;
    localparam int C_LSB   = 8;
    localparam int Y_MSB   = 7;
    localparam int Y_LSB   = 0;

    typedef enum logic [1:0] {
        SEARCH,
        ACTIVE,
        BLANK,
        DROP
    } state_e;

    // Expected P3..P0 for a given F/V/H.
    function automatic logic [3:0] xy_prot(input logic f, input logic v, input logic h);
        return {v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction

    // 00 and FF never occur as video samples; they only appear in timing codes.
    function automatic logic is_reserved(input logic [7:0] b);
        return (b == TRS_FF) || (b == TRS_00);
    endfunction

endpackage

// File: rtl/bt656_trs_detect.sv
// Byte history and XY decode of BT.656 timing reference codes; results are
// registered one cycle after XY. Protection check under BT656_PROT_CHECK_EN.
module bt656_trs_detect
    import bt656_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] byte_i,
    output logic       trs_vld_o,
    output logic       is_sav_o,
    output logic       is_eav_o,
    output logic       f_o,
    output logic       v_o,
    output logic       prot_err_o
);

    logic [7:0] hist1_q;
    logic [7:0] hist2_q;
    logic [7:0] hist3_q;
    logic       hdr_match;
    logic       prot_ok;
    logic       trs_vld_q;
    logic       f_q;
    logic       v_q;
    logic       h_q;

    assign hdr_match = (hist3_q == TRS_FF) && (hist2_q == TRS_00) &&
                       (hist1_q == TRS_00) && byte_i[7];

`ifdef BT656_PROT_CHECK_EN
    logic prot_err_q;

    assign prot_ok = (byte_i[3:0] == xy_prot(byte_i[6], byte_i[5], byte_i[4]));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prot_err_q <= 1'b0;
        end else begin
            prot_err_q <= hdr_match && !prot_ok;
        end
    end

    assign prot_err_o = prot_err_q;
`else
    assign prot_ok    = 1'b1;
    assign prot_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        hist1_q <= byte_i;
        hist2_q <= hist1_q;
        hist3_q <= hist2_q;
        if (hdr_match) begin
            f_q <= byte_i[6];
            v_q <= byte_i[5];
            h_q <= byte_i[4];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            trs_vld_q <= 1'b0;
        end else begin
            trs_vld_q <= hdr_match && prot_ok;
        end
    end

    assign trs_vld_o = trs_vld_q;
    assign is_sav_o  = trs_vld_q && !h_q;
    assign is_eav_o  = trs_vld_q && h_q;
    assign f_o       = f_q;
    assign v_o       = v_q;

endmodule

// File: rtl/bt656_decoder.sv
// BT.656 byte stream to {eop, sop, C, Y} FIFO words, one field per packet.
// Optional XY protection checking is enabled by defining BT656_PROT_CHECK_EN.
module bt656_decoder
    import bt656_pkg::*;
#(
    parameter int ACTIVE_PIXELS = 720,
    parameter int ACTIVE_LINES  = 288,
    parameter int DATA_WIDTH    = 18
) (
    input  logic                  Clk,
    input  logic                  Clear_in,
    input  logic [7:0]            Bt_data_in,
    output logic [DATA_WIDTH-1:0] Data_out,
    output logic                  WriteEn_out,
    input  logic                  Full_in,
    output logic                  Field_out,
    output logic                  Locked_out,
    output logic                  Overflow_out,
    output logic                  LineErr_out,
    output logic                  ProtErr_out
);

    // Pixel counter saturates one past a full line so overlong lines are flagged.
    localparam int PIX_W  = $clog2(ACTIVE_PIXELS + 2);
    localparam int LINE_W = $clog2(ACTIVE_LINES + 1);

    localparam logic [PIX_W-1:0]  AP_V      = PIX_W'(ACTIVE_PIXELS);
    localparam logic [PIX_W-1:0]  AP_LAST   = PIX_W'(ACTIVE_PIXELS - 1);
    localparam logic [LINE_W-1:0] AL_V      = LINE_W'(ACTIVE_LINES);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(ACTIVE_LINES - 1);

    logic trs_vld;
    logic trs_sav;
    logic trs_eav;
    logic trs_f;
    logic trs_v;
    logic prot_err;

    bt656_trs_detect u_trs (
        .clk_i      (Clk),
        .rst_i      (Clear_in),
        .byte_i     (Bt_data_in),
        .trs_vld_o  (trs_vld),
        .is_sav_o   (trs_sav),
        .is_eav_o   (trs_eav),
        .f_o        (trs_f),
        .v_o        (trs_v),
        .prot_err_o (prot_err)
    );

    state_e                state_q,    state_d;
    logic [1:0]            phase_q,    phase_d;
    logic [7:0]            c_q,        c_d;
    logic [PIX_W-1:0]      pix_q,      pix_d;
    logic [LINE_W-1:0]     line_q,     line_d;
    logic                  vseen_q,    vseen_d;
    logic                  locked_q,   locked_d;
    logic                  field_q,    field_d;
    logic                  ovf_q,      ovf_d;
    logic                  wr_q,       wr_d;
    logic [DATA_WIDTH-1:0] data_q,     data_d;
    logic                  line_err_q, line_err_d;

    logic       sav_act;
    logic       field_start;
    logic       start_line;
    logic       take_byte;
    logic [1:0] ph;
    logic       sop;
    logic       eop;

    // A field starts on the first V=0 SAV after any V=1 code.
    assign sav_act     = trs_sav && !trs_v;
    assign field_start = sav_act && vseen_q;
    assign sop         = (pix_q == '0) && (line_q == '0);
    assign eop         = (pix_q == AP_LAST) && (line_q == LINE_LAST);

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        c_d        = c_q;
        pix_d      = pix_q;
        line_d     = line_q;
        vseen_d    = vseen_q;
        locked_d   = locked_q;
        field_d    = field_q;
        ovf_d      = ovf_q;
        wr_d       = 1'b0;
        data_d     = data_q;
        line_err_d = 1'b0;
        start_line = 1'b0;
        take_byte  = 1'b0;
        ph         = phase_q;

        if (trs_vld && trs_v) begin
            vseen_d = 1'b1;
        end

        case (state_q)
            SEARCH: start_line = field_start;
            ACTIVE: begin
                if (trs_vld) begin
                    // Any SAV here abandons the partial line.
                    line_err_d = trs_sav || (trs_eav && (pix_q != AP_V));
                    start_line = sav_act;
                    if (!sav_act) begin
                        state_d = BLANK;
                    end
                end else begin
                    take_byte = 1'b1;
                end
            end
            BLANK:   start_line = sav_act;
            DROP:    start_line = field_start;
            default: state_d = SEARCH;
        endcase

        if (start_line) begin
            state_d   = ACTIVE;
            pix_d     = '0;
            ph        = 2'd0;
            take_byte = 1'b1;
            if (field_start) begin
                line_d   = '0;
                locked_d = 1'b1;
                field_d  = trs_f;
                vseen_d  = 1'b0;
            end else if (line_q != AL_V) begin
                line_d = line_q + 1'b1;
            end
        end

        // Words holding a reserved byte are the TRS preamble, never video.
        if (take_byte) begin
            phase_d = ph + 2'd1;
            if (!ph[0]) begin
                c_d = Bt_data_in;
            end else if (!is_reserved(c_q) && !is_reserved(Bt_data_in)) begin
                if (pix_q < AP_V) begin
                    if (Full_in) begin
                        ovf_d   = 1'b1;
                        state_d = DROP;
                    end else begin
                        wr_d                 = 1'b1;
                        data_d[EOP_BIT]      = eop;
                        data_d[SOP_BIT]      = sop;
                        data_d[C_MSB:C_LSB]  = c_q;
                        data_d[Y_MSB:Y_LSB]  = Bt_data_in;
                    end
                end
                if (pix_q <= AP_V) begin
                    pix_d = pix_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Clear_in) begin
            state_q    <= SEARCH;
            phase_q    <= 2'd0;
            pix_q      <= '0;
            line_q     <= '0;
            vseen_q    <= 1'b0;
            locked_q   <= 1'b0;
            field_q    <= 1'b0;
            ovf_q      <= 1'b0;
            wr_q       <= 1'b0;
            data_q     <= '0;
            line_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            pix_q      <= pix_d;
            line_q     <= line_d;
            vseen_q    <= vseen_d;
            locked_q   <= locked_d;
            field_q    <= field_d;
            ovf_q      <= ovf_d;
            wr_q       <= wr_d;
            data_q     <= data_d;
            line_err_q <= line_err_d;
        end
    end

    always_ff @(posedge Clk) begin
        c_q <= c_d;
    end

    assign Data_out     = data_q;
    assign WriteEn_out  = wr_q;
    assign Field_out    = field_q;
    assign Locked_out   = locked_q;
    assign Overflow_out = ovf_q;
    assign LineErr_out  = line_err_q;
    assign ProtErr_out  = prot_err;

endmodule

// File: tb/tb_bt656_decoder.sv
// Scoreboard bench for bt656_decoder on a tiny 4x2 field geometry.
module tb_bt656_decoder;

    localparam int AP = 4;
    localparam int AL = 2;

    logic        Clk = 1'b0;
    logic        Clear_in;
    logic [7:0]  Bt_data_in;
    logic [17:0] Data_out;
    logic        WriteEn_out;
    logic        Full_in;
    logic        Field_out;
    logic        Locked_out;
    logic        Overflow_out;
    logic        LineErr_out;
    logic        ProtErr_out;

    always #5 Clk = ~Clk;

    bt656_decoder #(
        .ACTIVE_PIXELS (AP),
        .ACTIVE_LINES  (AL),
        .DATA_WIDTH    (18)
    ) dut (
        .Clk          (Clk),
        .Clear_in     (Clear_in),
        .Bt_data_in   (Bt_data_in),
        .Data_out     (Data_out),
        .WriteEn_out  (WriteEn_out),
        .Full_in      (Full_in),
        .Field_out    (Field_out),
        .Locked_out   (Locked_out),
        .Overflow_out (Overflow_out),
        .LineErr_out  (LineErr_out),
        .ProtErr_out  (ProtErr_out)
    );

    logic [17:0] exp_q[$];
    int checks   = 0;
    int errors   = 0;
    int lerr_cnt = 0;
    int perr_cnt = 0;

    // Monitor: every write is popped against the scoreboard.
    always @(negedge Clk) begin
        if (LineErr_out) lerr_cnt++;
        if (ProtErr_out) perr_cnt++;
        if (WriteEn_out) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got=%05h want=none", Data_out);
            end else begin
                logic [17:0] w;
                w = exp_q.pop_front();
                if (Data_out !== w) begin
                    errors++;
                    $display("FAIL write_data got=%05h want=%05h", Data_out, w);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_data"},     32'(Data_out),     32'h0);
        chk({tag, "_wren"},     32'(WriteEn_out),  32'h0);
        chk({tag, "_field"},    32'(Field_out),    32'h0);
        chk({tag, "_locked"},   32'(Locked_out),   32'h0);
        chk({tag, "_overflow"}, 32'(Overflow_out), 32'h0);
        chk({tag, "_lineerr"},  32'(LineErr_out),  32'h0);
        chk({tag, "_proterr"},  32'(ProtErr_out),  32'h0);
    endtask

    task automatic send(input logic [7:0] b);
        Bt_data_in = b;
        @(negedge Clk);
    endtask

    task automatic trs(input logic [7:0] xy);
        send(8'hFF);
        send(8'h00);
        send(8'h00);
        send(xy);
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) begin
            send(8'h80);
            send(8'h10);
        end
    endtask

    // n words: C = seed+32*i, Y = C+0x10; Full_in high for word full_idx.
    task automatic pix(input int n, input logic [7:0] seed, input bit wr,
                       input int lidx, input int full_idx);
        for (int i = 0; i < n; i++) begin
            logic [7:0] c;
            logic [7:0] y;
            c = seed + 8'(32 * i);
            y = c + 8'h10;
            if (wr && i < AP && (full_idx < 0 || i < full_idx))
                exp_q.push_back({(i == AP-1 && lidx == AL-1), (i == 0 && lidx == 0), c, y});
            Full_in = (i == full_idx);
            send(c);
            send(y);
            Full_in = 1'b0;
        end
    endtask

    initial begin
        int l0;
        int p0;
        Clear_in   = 1'b1;
        Bt_data_in = 8'h10;
        Full_in    = 1'b0;
        repeat (3) @(negedge Clk);
        chk_idle("reset");
        Clear_in = 1'b0;
        blank(4);

        // Tiny field, F=0
        trs(8'hB6);
        blank(2);
        trs(8'h80);
        exp_q.push_back(18'h11020);
        exp_q.push_back(18'h03040);
        exp_q.push_back(18'h05060);
        exp_q.push_back(18'h07080);
        pix(4, 8'h10, 1'b0, 0, -1);
        trs(8'h9D);
        blank(2);
        trs(8'h80);
        pix(4, 8'h11, 1'b1, 1, -1);
        trs(8'h9D);
        blank(4);
        chk("tiny_locked", 32'(Locked_out), 32'h1);
        chk("tiny_field", 32'(Field_out), 32'h0);
        chk("tiny_lineerr_cnt", 32'(lerr_cnt), 32'h0);
        chk("tiny_all_written", 32'(exp_q.size()), 32'h0);

        // Overflow on 2nd word of an F=1 field, then drop until next field
        trs(8'hF1);
        blank(2);
        trs(8'hC7);
        pix(4, 8'h12, 1'b1, 0, 1);
        chk("ovf_set", 32'(Overflow_out), 32'h1);
        chk("ovf_field", 32'(Field_out), 32'h1);
        trs(8'hDA);
        blank(2);
        trs(8'hC7);
        pix(4, 8'h13, 1'b0, 1, -1);
        trs(8'hDA);
        blank(2);
        trs(8'hB6);
        blank(2);
        trs(8'h80);
        pix(4, 8'h14, 1'b1, 0, -1);
        trs(8'h9D);
        blank(2);
        trs(8'h80);
        pix(4, 8'h15, 1'b1, 1, -1);
        trs(8'h9D);
        blank(4);
        chk("ovf_sticky", 32'(Overflow_out), 32'h1);
        chk("ovf_refield", 32'(Field_out), 32'h0);
        chk("ovf_all_written", 32'(exp_q.size()), 32'h0);

        // Short last line: one LineErr, no eop
        l0 = lerr_cnt;
        trs(8'hB6);
        blank(2);
        trs(8'h80);
        pix(4, 8'h16, 1'b1, 0, -1);
        trs(8'h9D);
        blank(2);
        trs(8'h80);
        pix(3, 8'h17, 1'b1, 1, -1);
        trs(8'h9D);
        blank(4);
        chk("short_lineerr", 32'(lerr_cnt - l0), 32'h1);

        // Timing code inserted mid-line
        l0 = lerr_cnt;
        trs(8'hB6);
        blank(2);
        trs(8'h80);
        pix(2, 8'h18, 1'b1, 0, -1);
        trs(8'h80);
        pix(4, 8'h19, 1'b1, 1, -1);
        trs(8'h9D);
        blank(4);
        chk("midtrs_lineerr", 32'(lerr_cnt - l0), 32'h1);
        chk("midtrs_all_written", 32'(exp_q.size()), 32'h0);

        // Corrupted SAV protection bits (0x80 -> 0x81)
        p0 = perr_cnt;
        trs(8'hB6);
        blank(2);
        trs(8'h81);
`ifdef BT656_PROT_CHECK_EN
        pix(4, 8'h1A, 1'b0, 0, -1);
`else
        pix(4, 8'h1A, 1'b1, 0, -1);
`endif
        trs(8'h9D);
        blank(4);
`ifdef BT656_PROT_CHECK_EN
        chk("prot_err_cnt", 32'(perr_cnt - p0), 32'h1);
`else
        chk("prot_err_cnt", 32'(perr_cnt - p0), 32'h0);
`endif
        chk("prot_all_written", 32'(exp_q.size()), 32'h0);

        // Clear mid-line
        trs(8'hB6);
        blank(2);
        trs(8'h80);
        pix(2, 8'h1B, 1'b1, 0, -1);
        Clear_in = 1'b1;
        send(8'h55);
        Clear_in = 1'b0;
        chk_idle("clear");
        pix(2, 8'h1C, 1'b0, 0, -1);
        trs(8'h80);
        pix(2, 8'h1D, 1'b0, 0, -1);
        blank(2);
        chk("clear_unlocked", 32'(Locked_out), 32'h0);
        trs(8'hB6);
        blank(2);
        trs(8'h80);
        pix(4, 8'h1E, 1'b1, 0, -1);
        trs(8'h9D);
        blank(8);
        chk("relock", 32'(Locked_out), 32'h1);
        chk("final_all_written", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
